apb_master_bridge: RTL
======================

// Module: apb_master_bridge
// PURPOSE
//  APB requester. Accepts single read/write commands from a local valid/ready command port.
//  Runs them as APB SETUP -> ACCESS transfers toward up to 4 address-decoded APB slaves.
//  Returns the read data and error status on a one-cycle response strobe.
//  Sits between a local bus/CPU-side agent and the APB slave bank (slave select = PADDR[31:30]).
// PARAMETERS
//  ADDR_WIDTH      32    address width (shared_pkg)
//  DATA_WIDTH      32    data width (shared_pkg); PSTRB_WIDTH = DATA_WIDTH/8
//  NUM_SLAVES      4     PSEL vector width; slave index = PADDR[ADDR_WIDTH-1:ADDR_WIDTH-2]
//  TIMEOUT_CYCLES  16    max ACCESS cycles waiting for PREADY (only with APB_MASTER_TIMEOUT_EN)
// PORTS
//  PCLK         in   1            clock, all logic on rising edge
//  PRESET       in   1            reset, synchronous, active-high
//  cmd_valid    in   1            command offered
//  cmd_ready    out  1            command accepted when cmd_valid&&cmd_ready
//  cmd_write    in   1            1=write, 0=read
//  cmd_addr     in   ADDR_WIDTH   byte address
//  cmd_wdata    in   DATA_WIDTH   write data
//  cmd_strb     in   PSTRB_WIDTH  write byte strobes
//  cmd_prot     in   3            protection attributes
//  rsp_valid    out  1            one-cycle pulse: transfer finished
//  rsp_rdata    out  DATA_WIDTH   read data (0 for writes)
//  rsp_slverr   out  1            PSLVERR sampled at completion, or timeout
//  rsp_timeout  out  1            transfer aborted by watchdog
//  PSEL         out  NUM_SLAVES   one-hot slave select
//  PENABLE      out  1            ACCESS phase
//  PADDR        out  ADDR_WIDTH
//  PWRITE       out  1
//  PWDATA       out  DATA_WIDTH
//  PSTRB        out  PSTRB_WIDTH  forced 0 on reads
//  PPROT        out  3
//  PREADY       in   1            slave completion
//  PRDATA       in   DATA_WIDTH
//  PSLVERR      in   1
// BEHAVIOUR
//  - Reset (PRESET=1 at a PCLK edge): state IDLE; every output 0 (incl. cmd_ready, rsp_*).
//  - Reset mid-transfer: drop PSEL/PENABLE next edge; no rsp_valid for the aborted command.
//  - All APB outputs and rsp_* are registered. cmd_ready = (state==IDLE) | (state==ACCESS & PREADY).
//  - FSM IDLE -> SETUP:
//    - on accept, latch cmd into PADDR/PWRITE/PWDATA/PPROT and PSTRB (cmd_strb if write, else 0).
//    - PSEL[cmd_addr[ADDR_WIDTH-1 -: 2]] <= 1, PENABLE <= 0.
//  - SETUP -> ACCESS: unconditional after 1 cycle; PENABLE <= 1; PSEL/PADDR/PWRITE/PWDATA/PSTRB/PPROT held stable.
//  - ACCESS, PREADY=0: stay, all APB outputs stable.
//  - ACCESS, PREADY=1: complete.
//    - rsp_valid <= 1; rsp_rdata <= PWRITE ? 0 : PRDATA; rsp_slverr <= PSLVERR.
//    - If cmd_valid in same cycle: accept, go straight to SETUP (PENABLE 0, new PSEL), no idle gap.
//    - Else go to IDLE with PSEL=0, PENABLE=0. PADDR/PWDATA keep their last values.
//  - Minimum transfer: 2 APB cycles; command accept -> rsp_valid = 3 edges with a zero-wait slave.
//  - rsp_valid is high for exactly 1 cycle. There is no response backpressure; the consumer must sink it.
//  - NUM_SLAVES < 4: an index >= NUM_SLAVES selects nothing. The transfer completes after SETUP+1 ACCESS
//    cycle with rsp_slverr=1, rsp_rdata=0, and no PSEL asserted.
//  - Misaligned addresses are passed through unchanged; error detection is the slave's job.
// CONFIGURATION
//  APB_MASTER_TIMEOUT_EN defined:
//    - 16-bit wait counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
//    - When the counter reaches TIMEOUT_CYCLES-1 with PREADY still 0: PSEL/PENABLE <= 0, state IDLE,
//      rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
//    - PREADY=1 in that same cycle wins (normal completion).
//  Not defined: no counter; ACCESS waits indefinitely; rsp_timeout tied 0.
// STRUCTURE
//  shared_pkg: ADDR_WIDTH, DATA_WIDTH, PSTRB_WIDTH, typedef enum logic[1:0] {M_IDLE,M_SETUP,M_ACCESS}
//  apb_master_state_t, typedef struct apb_cmd_t {write,addr,wdata,strb,prot}.
//  Sub-module apb_psel_decode: combinational addr -> one-hot PSEL, plus a valid flag.
// TESTING
//  1 write 0x4000_0010 data 0xDEAD_BEEF strb 0xF, PREADY=1 -> PSEL=4'b0010, SETUP then ACCESS,
//    rsp_valid 3rd edge, slverr 0
//  2 read 0x8000_0004, PREADY low 3 cycles, PRDATA 0x1234_5678 -> PENABLE high 4 cycles,
//    PSTRB=0, rsp_rdata 0x1234_5678
//  3 two back-to-back cmds (cmd_valid held) -> second SETUP immediately after first ACCESS
//    completion, no IDLE cycle
//  4 write with PSLVERR=1 at completion -> rsp_slverr=1, rsp_timeout=0
//  5 TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY never -> abort after 16 ACCESS cycles, slverr=1,
//    timeout=1; without macro still waiting at cycle 100
//  6 assert PRESET during ACCESS -> next edge PSEL=0, PENABLE=0, no rsp_valid, cmd_ready=0
//    until release

Source files
------------

// File: rtl/shared_pkg.sv
// Shared widths, FSM state encoding and latched-command type for the APB requester.
package shared_pkg;
    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int PSTRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        M_IDLE,
        M_SETUP,
        M_ACCESS
    } apb_master_state_t;

    typedef struct packed {
        logic                   write;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0]  wdata;
        logic [PSTRB_WIDTH-1:0] strb;
        logic [2:0]             prot;
    } apb_cmd_t;
endpackage

// File: rtl/apb_psel_decode.sv
// Combinational slave decode: 2-bit region index -> one-hot select plus "slave exists" flag.
module apb_psel_decode #(
    parameter int NUM_SLAVES = 4
) (
    input  logic [1:0]            idx,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  valid
);
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            assign sel[gi] = (idx == 2'(gi));
        end
    endgenerate

    // Regions beyond NUM_SLAVES select nothing and are answered locally with an error.
    assign valid = ({30'd0, idx} < NUM_SLAVES);
endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: valid/ready command port -> APB SETUP/ACCESS transfer -> one-cycle response strobe.
// Optional ACCESS watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
    import shared_pkg::*;
#(
    parameter int NUM_SLAVES = 4
`ifdef APB_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]  cmd_wdata,
    input  logic [PSTRB_WIDTH-1:0] cmd_strb,
    input  logic [2:0]             cmd_prot,
    output logic                   rsp_valid,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   rsp_slverr,
    output logic                   rsp_timeout,
    output logic [NUM_SLAVES-1:0]  PSEL,
    output logic                   PENABLE,
    output logic [ADDR_WIDTH-1:0]  PADDR,
    output logic                   PWRITE,
    output logic [DATA_WIDTH-1:0]  PWDATA,
    output logic [PSTRB_WIDTH-1:0] PSTRB,
    output logic [2:0]             PPROT,
    input  logic                   PREADY,
    input  logic [DATA_WIDTH-1:0]  PRDATA,
    input  logic                   PSLVERR
);
    apb_master_state_t     state_reg, state_next;
    apb_cmd_t              cmd_reg, cmd_next;
    logic [NUM_SLAVES-1:0] psel_reg, psel_next;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_valid;
    logic                  penable_reg, penable_next;
    logic                  sel_valid_reg, sel_valid_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic                  rsp_slverr_reg, rsp_slverr_next;
    logic                  access_done;
    logic                  accept;
`ifdef APB_MASTER_TIMEOUT_EN
    logic [15:0]           wait_cnt_reg, wait_cnt_next;
    logic                  rsp_timeout_reg, rsp_timeout_next;
`endif

    apb_psel_decode #(
        .NUM_SLAVES(NUM_SLAVES)
    ) u_decode (
        .idx  (cmd_addr[ADDR_WIDTH-1 -: 2]),
        .sel  (dec_sel),
        .valid(dec_valid)
    );

    // A transfer to a non-existent slave finishes after one ACCESS cycle without PREADY.
    assign access_done = (state_reg == M_ACCESS) && (PREADY || !sel_valid_reg);
    assign cmd_ready   = !PRESET && ((state_reg == M_IDLE) || access_done);
    assign accept      = cmd_valid && cmd_ready;

    always_comb begin
        state_next      = state_reg;
        cmd_next        = cmd_reg;
        psel_next       = psel_reg;
        penable_next    = penable_reg;
        sel_valid_next  = sel_valid_reg;
        rsp_valid_next  = 1'b0;
        rsp_rdata_next  = '0;
        rsp_slverr_next = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_next    = wait_cnt_reg;
        rsp_timeout_next = 1'b0;
`endif
        case (state_reg)
            M_SETUP: begin
                state_next   = M_ACCESS;
                penable_next = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                wait_cnt_next = '0;
`endif
            end
            M_ACCESS: begin
                if (access_done) begin
                    rsp_valid_next  = 1'b1;
                    rsp_slverr_next = PSLVERR || !sel_valid_reg;
                    if (sel_valid_reg && !cmd_reg.write) begin
                        rsp_rdata_next = PRDATA;
                    end
                    state_next   = M_IDLE;
                    psel_next    = '0;
                    penable_next = 1'b0;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (wait_cnt_reg == 16'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_next   = 1'b1;
                    rsp_slverr_next  = 1'b1;
                    rsp_timeout_next = 1'b1;
                    state_next       = M_IDLE;
                    psel_next        = '0;
                    penable_next     = 1'b0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                end
`endif
            end
            default: ;
        endcase

        // Accept overrides the IDLE fall-back so back-to-back commands have no idle gap.
        if (accept) begin
            state_next     = M_SETUP;
            cmd_next.write = cmd_write;
            cmd_next.addr  = cmd_addr;
            cmd_next.wdata = cmd_wdata;
            cmd_next.strb  = cmd_write ? cmd_strb : '0;
            cmd_next.prot  = cmd_prot;
            psel_next      = dec_sel;
            penable_next   = 1'b0;
            sel_valid_next = dec_valid;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg      <= M_IDLE;
            cmd_reg        <= '0;
            psel_reg       <= '0;
            penable_reg    <= 1'b0;
            sel_valid_reg  <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_rdata_reg  <= '0;
            rsp_slverr_reg <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_reg    <= '0;
            rsp_timeout_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cmd_reg        <= cmd_next;
            psel_reg       <= psel_next;
            penable_reg    <= penable_next;
            sel_valid_reg  <= sel_valid_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_rdata_reg  <= rsp_rdata_next;
            rsp_slverr_reg <= rsp_slverr_next;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_reg    <= wait_cnt_next;
            rsp_timeout_reg <= rsp_timeout_next;
`endif
        end
    end

    assign PSEL       = psel_reg;
    assign PENABLE    = penable_reg;
    assign PADDR      = cmd_reg.addr;
    assign PWRITE     = cmd_reg.write;
    assign PWDATA     = cmd_reg.wdata;
    assign PSTRB      = cmd_reg.strb;
    assign PPROT      = cmd_reg.prot;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_rdata  = rsp_rdata_reg;
    assign rsp_slverr = rsp_slverr_reg;
`ifdef APB_MASTER_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_reg;
`else
    assign rsp_timeout = 1'b0;
`endif
endmodule
